// File: rtl/out_port_fifo.sv
// Output-port FIFO behind the BURP core: buffers OUT_wire values and hands them
// to an external consumer over valid/ready, reporting full and a sticky overflow.
module out_port_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             out_we,
    input  logic [WIDTH-1:0] out_data,
    output logic             full,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic [AW:0]      count,
    output logic             overflow,
    input  logic             overflow_clr
);

    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             full_r;
    logic             valid_r;
    logic             overflow_r;

    logic             wr_acc_s;
    logic             rd_acc_s;
    logic [AW:0]      count_next_s;

    // Accept decisions use only registered flags, so out_ready never reaches full
    // and out_we never reaches out_valid combinationally.
    always_comb begin
        wr_acc_s     = out_we && !full_r;
        rd_acc_s     = valid_r && out_ready;
        count_next_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Storage array: written on accepted writes only, never cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc_s) begin
            mem_r[wr_ptr_r] <= out_data;
        end
    end

    // Pointer, occupancy and status registers; full/valid are pre-decoded from
    // the next count so they come straight out of flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
            full_r     <= 1'b0;
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == FULL_COUNT);
            valid_r <= (count_next_s != {(AW+1){1'b0}});
            // A rejected write in the same cycle as a clear keeps the flag set.
            if (out_we && full_r) begin
                overflow_r <= 1'b1;
            end else if (overflow_clr) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Head entry is masked to zero whenever nothing is valid.
    always_comb begin
        if (valid_r) begin
            out_q = mem_r[rd_ptr_r];
        end else begin
            out_q = {WIDTH{1'b0}};
        end
    end

    assign full      = full_r;
    assign out_valid = valid_r;
    assign count     = count_r;
    assign overflow  = overflow_r;

endmodule
